// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit pipelined CPU.
//   PC_W          - program counter / address width
//   OPC_HLT       - opcode (instr[15:12]) of the halt instruction
//   NOP_INSTR     - encoding loaded into pipeline registers on a bubble
//   fetch_state_t - fetch-stage sequencing states
//   is_hlt()      - decodes a HLT from a raw instruction word
package cpu_pkg;

  localparam int unsigned PC_W = 16;

  localparam logic [3:0]  OPC_HLT   = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  function automatic logic is_hlt(input logic [15:0] instr);
    return instr[15:12] == OPC_HLT;
  endfunction

endpackage

// File: rtl/CLA_16bit.sv
// CLA_16bit: 16-bit carry-lookahead adder built from four 4-bit groups.
// Bit carries inside a group are fully expanded; group carries come from a
// second-level lookahead over group generate/propagate terms.
//   A, B   - operands
//   C_in   - carry in
//   Sum    - A + B + C_in (mod 2^16)
//   C_out  - carry out of bit 15
module CLA_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] Sum,
  output logic        C_out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;      // carry into each bit
  logic [3:0]  gg;     // group generate
  logic [3:0]  gp;     // group propagate
  logic [4:0]  gc;     // carry into each group, gc[4] = carry out

  assign g = A & B;
  assign p = A ^ B;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int b = gi * 4;
      assign c[b]     = gc[gi];
      assign c[b + 1] = g[b] | (p[b] & gc[gi]);
      assign c[b + 2] = g[b + 1] | (p[b + 1] & g[b]) | (p[b + 1] & p[b] & gc[gi]);
      assign c[b + 3] = g[b + 2] | (p[b + 2] & g[b + 1]) | (p[b + 2] & p[b + 1] & g[b])
                      | (p[b + 2] & p[b + 1] & p[b] & gc[gi]);
      assign gp[gi] = &p[b +: 4];
      assign gg[gi] = g[b + 3] | (p[b + 3] & g[b + 2]) | (p[b + 3] & p[b + 2] & g[b + 1])
                    | (p[b + 3] & p[b + 2] & p[b + 1] & g[b]);
    end
  endgenerate

  assign gc[0] = C_in;
  assign gc[1] = gg[0] | (gp[0] & gc[0]);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & gc[0]);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);

  assign Sum   = p ^ c;
  assign C_out = gc[4];

endmodule

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold and bubble-load controls.
//   clk, rst_n   - clock, synchronous active-low reset (loads a bubble)
//   hold_i       - keep current contents
//   flush_i      - load a bubble (NOP_INSTR, pc_plus2 0, valid 0); beats hold_i
//   instr_i      - instruction to latch
//   pc_plus2_i   - PC+2 of that instruction
//   instr_o, pc_plus2_o, valid_o - registered contents
module if_id_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic [15:0]     instr_i,
  input  logic [PC_W-1:0] pc_plus2_i,
  output logic [15:0]     instr_o,
  output logic [PC_W-1:0] pc_plus2_o,
  output logic            valid_o
);

  logic [15:0]     instr_q;
  logic [PC_W-1:0] pc_plus2_q;
  logic            valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
    end else if (!hold_i) begin
      instr_q    <= instr_i;
      pc_plus2_q <= pc_plus2_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus2_o = pc_plus2_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: instruction fetch for the 16-bit pipelined CPU.
// Owns the PC, loads IF/ID, applies ID-stage branch redirects and hazard
// stalls, and freezes fetch once a fetched HLT has drained down the pipe.
//   clk, rst_n      - clock, synchronous active-low reset
//   stall           - hold PC and IF/ID
//   redirect_valid  - taken branch in ID; flushes IF
//   redirect_pc     - branch target (bit 0 forced to 0)
//   imem_addr       - instruction-memory address (PC register)
//   imem_data       - instruction at imem_addr (same-cycle read)
//   if_id_instr, if_id_pc_plus2, if_id_valid - IF/ID contents
//   halted          - sticky until reset
module pc_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [15:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc_plus2,
  output logic            if_id_valid,
  output logic            halted
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic            halted_q;

  logic [PC_W-1:0] pc_plus2;
  logic            ifid_hold, ifid_flush;
  logic            fetch_hlt;
  logic            cla_cout_unused;
  logic            redirect_lsb_unused;

  assign redirect_lsb_unused = redirect_pc[0];

  CLA_16bit u_pc_add (
    .A     (pc_q),
    .B     (16'h0002),
    .C_in  (1'b0),
    .Sum   (pc_plus2),
    .C_out (cla_cout_unused)
  );

  // A HLT only takes effect when it is actually fetched: not under
  // stall and not when a redirect is squashing the IF slot.
  assign fetch_hlt = (state_q == RUN) && !redirect_valid && !stall && is_hlt(imem_data);

  always_comb begin
    pc_d       = pc_q;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_d       = {redirect_pc[PC_W-1:1], 1'b0};
          ifid_flush = 1'b1;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else if (!is_hlt(imem_data)) begin
          pc_d = pc_plus2;
        end
      end
      DRAIN: begin
        ifid_hold  = stall;
        ifid_flush = !stall;
      end
      default: ifid_flush = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      unique case (state_q)
        RUN: begin
          if (fetch_hlt) begin
            state_q <= DRAIN;
            cnt_q   <= CNT_W'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (!stall) begin
            // Last drain cycle: move straight to HALTED rather than
            // spending an extra edge at count zero.
            if (cnt_q <= CNT_W'(1)) begin
              state_q  <= HALTED;
              cnt_q    <= '0;
              halted_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        default: halted_q <= 1'b1;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold_i     (ifid_hold),
    .flush_i    (ifid_flush),
    .instr_i    (imem_data),
    .pc_plus2_i (pc_plus2),
    .instr_o    (if_id_instr),
    .pc_plus2_o (if_id_pc_plus2),
    .valid_o    (if_id_valid)
  );

  assign imem_addr = pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed-vector bench for pc_fetch_stage.
// Instruction memory returns {4'h1, addr[11:0]} except at hlt_addr when
// hlt_en is set, where it returns a HLT (16'hF000).
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] if_id_instr, if_id_pc_plus2;
  logic        if_id_valid, halted;

  logic [15:0] w_imem_addr, w_imem_data;
  logic [15:0] w_if_id_instr, w_if_id_pc_plus2;
  logic        w_if_id_valid, w_halted;

  logic        hlt_en;
  logic [15:0] hlt_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a, input logic en, input logic [15:0] ha);
    if (en && a == ha) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  assign imem_data   = mem(imem_addr, hlt_en, hlt_addr);
  assign w_imem_data = mem(w_imem_addr, hlt_en, hlt_addr);

  pc_fetch_stage #(.RESET_PC(16'h0000), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_instr(if_id_instr), .if_id_pc_plus2(if_id_pc_plus2),
    .if_id_valid(if_id_valid), .halted(halted)
  );

  pc_fetch_stage #(.RESET_PC(16'hFFFE), .DRAIN_CYCLES(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .if_id_instr(w_if_id_instr), .if_id_pc_plus2(w_if_id_pc_plus2),
    .if_id_valid(w_if_id_valid), .halted(w_halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    $display("[TB] cyc %0d addr=%h instr=%h pp2=%h v=%b halted=%b", cyc, imem_addr,
             if_id_instr, if_id_pc_plus2, if_id_valid, halted);
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] ins, input logic [15:0] pp2,
                            input logic v);
    check({tag, ".instr"}, {16'h0, if_id_instr}, {16'h0, ins});
    check({tag, ".pp2"}, {16'h0, if_id_pc_plus2}, {16'h0, pp2});
    check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, v});
  endtask

  task automatic check_addr(input string tag, input logic [15:0] a);
    check(tag, {16'h0, imem_addr}, {16'h0, a});
  endtask

  task automatic redirect_to(input logic [15:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    hlt_en = 1'b0; hlt_addr = 16'h0;
    #1;
    step(); step();

    // Reset state
    check_addr("rst.addr", 16'h0000);
    check_ifid("rst", 16'h0000, 16'h0000, 1'b0);
    check("rst.halted", {31'h0, halted}, 32'h0);
    check("rst.wrap_addr", {16'h0, w_imem_addr}, 32'h0000_FFFE);

    // Straight-line fetch; second instance wraps FFFE -> 0000
    rst_n = 1'b1;
    step();
    check_addr("seq1.addr", 16'h0002);
    check_ifid("seq1", 16'h1000, 16'h0002, 1'b1);
    check("wrap.addr", {16'h0, w_imem_addr}, 32'h0);
    check("wrap.pp2", {16'h0, w_if_id_pc_plus2}, 32'h0);
    step();
    check_addr("seq2.addr", 16'h0004);
    check_ifid("seq2", 16'h1002, 16'h0004, 1'b1);
    step();
    check_addr("seq3.addr", 16'h0006);
    check_ifid("seq3", 16'h1004, 16'h0006, 1'b1);
    repeat (5) step();
    check_addr("seq.addr10", 16'h0010);

    // Redirect with odd target
    redirect_to(16'h0041);
    check_addr("br.addr", 16'h0040);
    check_ifid("br.bubble", 16'h0000, 16'h0000, 1'b0);
    step();
    check_addr("br.next", 16'h0042);
    check_ifid("br.tgt", 16'h1040, 16'h0042, 1'b1);

    // Stall holds, then stall+redirect together
    redirect_to(16'h001E);
    step();
    check_addr("st.addr0", 16'h0020);
    check_ifid("st.ifid0", 16'h101E, 16'h0020, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_addr("st.addr", 16'h0020);
      check_ifid("st.hold", 16'h101E, 16'h0020, 1'b1);
    end
    redirect_to(16'h0100);
    stall = 1'b0;
    check_addr("stbr.addr", 16'h0100);
    check_ifid("stbr.bubble", 16'h0000, 16'h0000, 1'b0);
    step();
    check_addr("stbr.next", 16'h0102);
    check_ifid("stbr.tgt", 16'h1100, 16'h0102, 1'b1);

    // Flushed HLT: HLT at imem_data while redirecting
    hlt_en = 1'b1; hlt_addr = 16'h0102;
    redirect_to(16'h0030);
    check_addr("fh.addr", 16'h0030);
    check_ifid("fh.bubble", 16'h0000, 16'h0000, 1'b0);
    step();
    check_addr("fh.next", 16'h0032);
    check_ifid("fh.tgt", 16'h1030, 16'h0032, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("fh.halted", {31'h0, halted}, 32'h0);
    end

    // HLT drain, no stalls
    hlt_addr = 16'h0008;
    redirect_to(16'h0008);
    step();
    check_addr("hlt.addr", 16'h0008);
    check_ifid("hlt.ifid", 16'hF000, 16'h000A, 1'b1);
    check("hlt.halted0", {31'h0, halted}, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_addr("hlt.dr.addr", 16'h0008);
      check_ifid("hlt.dr", 16'h0000, 16'h0000, 1'b0);
      check("hlt.dr.halted", {31'h0, halted}, 32'h0);
    end
    step();
    check("hlt.halted4", {31'h0, halted}, 32'h1);
    redirect_to(16'h0200);
    check("hlt.sticky", {31'h0, halted}, 32'h1);
    check_addr("hlt.frozen", 16'h0008);
    check_ifid("hlt.bubble", 16'h0000, 16'h0000, 1'b0);

    // HLT drain with 2 stalled cycles
    rst_n = 1'b0; hlt_addr = 16'h0000;
    step();
    check("rst2.halted", {31'h0, halted}, 32'h0);
    rst_n = 1'b1;
    step();
    check_ifid("hs.ifid", 16'hF000, 16'h0002, 1'b1);
    check_addr("hs.addr", 16'h0000);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_ifid("hs.hold", 16'hF000, 16'h0002, 1'b1);
      check("hs.st.halted", {31'h0, halted}, 32'h0);
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hs.dr.halted", {31'h0, halted}, 32'h0);
    end
    step();
    check("hs.halted", {31'h0, halted}, 32'h1);

    // Reset during DRAIN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    check_addr("rd.addr", 16'h0000);
    check("rd.halted", {31'h0, halted}, 32'h0);
    check_ifid("rd", 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b1; hlt_en = 1'b0;
    step();
    check_addr("rd.run", 16'h0002);
    check_ifid("rd.run", 16'h1000, 16'h0002, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("rd.nohalt", {31'h0, halted}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
